bcd_scan_controller: RTL and testbench

- Parametrised, time-multiplexed digit-scan controller for the multiplier's seven-segment display.
- Owns the refresh prescaler and digit index. Double-buffers the BCD result so a frame is never torn.
- Drives the selected BCD digit and active-low anode enables to the downstream segment decoder.

---
 rtl/bcd_scan_controller.sv | 142 ++++++++++++++
 tb/tb_bcd_scan_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_controller.sv
// Time-multiplexed digit-scan controller for the multiplier's seven-segment display.
// Latency: outputs are registered and change on the same edge as the digit index; captured values reach the display at the next frame boundary.
// Backpressure: none. cargar is accepted every cycle, and a newer value overwrites any pending one.
//
// Ports:
//   clk, rst_n           system clock and synchronous active-low reset
//   habilitar            1 = scan running, 0 = display blanked (prescaler and index held)
//   cargar, codigo_BCD   capture strobe and packed BCD value (digit 0 = units)
//   digito, anodo_n      selected BCD digit and active-low anode enables
//   contador_actualizar  current digit index
//   fin_cuadro           one-cycle pulse after each frame wrap
//   error_bcd            sticky flag set when a captured nibble is > 9
// Optional feature: define BCD_SCAN_LZB_EN to blank leading zeros.
module bcd_scan_controller #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int IDX_W       = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    habilitar,
  input  logic                    cargar,
  input  logic [4*NUM_DIGITS-1:0] codigo_BCD,
  output logic [3:0]              digito,
  output logic [NUM_DIGITS-1:0]   anodo_n,
  output logic [IDX_W-1:0]        contador_actualizar,
  output logic                    fin_cuadro,
  output logic                    error_bcd
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  logic [PW-1:0]         presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [3:0]            digito_q, digito_d;
  logic [NUM_DIGITS-1:0] anodo_n_q, anodo_n_d;
  logic                  fin_cuadro_q, fin_cuadro_d;
  logic                  error_q, error_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [DW-1:0]         pending_q, pending_d;
  logic                  pend_q, pend_d;

  logic tick;
  logic boundary;
  logic bad_nibble;
  int   msd;

  always_comb begin
    tick     = habilitar && (presc_q == PW'(REFRESH_DIV - 1));
    boundary = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

    // Prescaler and index freeze (not clear) while scanning is disabled.
    presc_d = presc_q;
    idx_d   = idx_q;
    if (habilitar) begin
      if (tick) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    fin_cuadro_d = boundary;

    bad_nibble = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (codigo_BCD[4*k +: 4] > 4'd9) bad_nibble = 1'b1;
    end
    error_d = error_q || (cargar && bad_nibble);

    // Double buffer: the shadow only changes at a frame boundary. A load in
    // the boundary cycle itself bypasses the pending register.
    shadow_d  = shadow_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    if (boundary) begin
      if (cargar) begin
        shadow_d = codigo_BCD;
        pend_d   = 1'b0;
      end else if (pend_q) begin
        shadow_d = pending_q;
        pend_d   = 1'b0;
      end
    end else if (cargar) begin
      pending_d = codigo_BCD;
      pend_d    = 1'b1;
    end

    // Highest nonzero digit of the value being displayed; digit 0 always counts.
    msd = 0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (shadow_d[4*k +: 4] != 4'd0) msd = k;
    end

    // Outputs are driven from next-state values so they move with the index.
    digito_d  = 4'd0;
    anodo_n_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        digito_d = shadow_d[4*k +: 4];
`ifdef BCD_SCAN_LZB_EN
        anodo_n_d[k] = !(habilitar && (k <= msd));
`else
        anodo_n_d[k] = !habilitar;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      digito_q     <= 4'd0;
      anodo_n_q    <= '1;
      fin_cuadro_q <= 1'b0;
      error_q      <= 1'b0;
      shadow_q     <= '0;
      pending_q    <= '0;
      pend_q       <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      digito_q     <= digito_d;
      anodo_n_q    <= anodo_n_d;
      fin_cuadro_q <= fin_cuadro_d;
      error_q      <= error_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_q       <= pend_d;
    end
  end

  assign digito              = digito_q;
  assign anodo_n             = anodo_n_q;
  assign contador_actualizar = idx_q;
  assign fin_cuadro          = fin_cuadro_q;
  assign error_bcd           = error_q;

endmodule

// File: tb/tb_bcd_scan_controller.sv
// Testbench for bcd_scan_controller with NUM_DIGITS=4 and REFRESH_DIV=4.
// The reference model tracks the count of enabled cycles and the buffered values.
// Directed scenarios run first, followed by randomized traffic.
module tb_bcd_scan_controller;
  localparam int N     = 4;
  localparam int RD    = 4;
  localparam int IW    = 3;
  localparam int FRAME = N * RD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          habilitar;
  logic          cargar;
  logic [4*N-1:0] codigo_BCD;
  logic [3:0]    digito;
  logic [N-1:0]  anodo_n;
  logic [IW-1:0] contador_actualizar;
  logic          fin_cuadro;
  logic          error_bcd;

  bcd_scan_controller #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .habilitar(habilitar), .cargar(cargar),
    .codigo_BCD(codigo_BCD), .digito(digito), .anodo_n(anodo_n),
    .contador_actualizar(contador_actualizar), .fin_cuadro(fin_cuadro),
    .error_bcd(error_bcd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int unsigned pos;       // enabled cycles since reset
  int unsigned m_shadow;
  int unsigned m_pending;
  bit          m_pend;
  bit          m_err;
  bit          m_fin;
  bit          m_en;      // habilitar as sampled at the last edge (0 after reset)

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned cur_idx();
    return (pos / RD) % N;
  endfunction

  function automatic int unsigned nib(input int unsigned v, input int unsigned k);
    return (v >> (4 * k)) & 32'hF;
  endfunction

  task automatic model_edge();
    bit boundary;
    if (!rst_n) begin
      pos = 0; m_shadow = 0; m_pending = 0; m_pend = 0;
      m_err = 0; m_fin = 0; m_en = 0;
      return;
    end
    boundary = habilitar && ((pos % FRAME) == FRAME - 1);
    if (cargar)
      for (int k = 0; k < N; k++) if (nib(codigo_BCD, k) > 9) m_err = 1;
    if (boundary) begin
      if (cargar) begin m_shadow = codigo_BCD; m_pend = 0; end
      else if (m_pend) begin m_shadow = m_pending; m_pend = 0; end
    end else if (cargar) begin
      m_pending = codigo_BCD; m_pend = 1;
    end
    if (habilitar) pos++;
    m_fin = boundary;
    m_en  = habilitar;
  endtask

  function automatic logic [N-1:0] exp_anodo();
    logic [N-1:0] a;
    int top;
    a = '1;
    top = N - 1;
`ifdef BCD_SCAN_LZB_EN
    top = 0;
    for (int k = 0; k < N; k++) if (nib(m_shadow, k) != 0) top = k;
`endif
    if (m_en && (int'(cur_idx()) <= top)) a[cur_idx()] = 1'b0;
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("digito", 32'(digito), nib(m_shadow, cur_idx()));
    chk("anodo_n", 32'(anodo_n), 32'(exp_anodo()));
    chk("idx", 32'(contador_actualizar), cur_idx());
    chk("fin_cuadro", 32'(fin_cuadro), 32'(m_fin));
    chk("error_bcd", 32'(error_bcd), 32'(m_err));
  endtask

  task automatic pulse_load(input logic [15:0] v);
    cargar = 1'b1; codigo_BCD = v;
    step();
    cargar = 1'b0;
  endtask

  // Advance until the model sits at frame offset 'target'; bounded.
  task automatic run_to(input int unsigned target);
    int n = 0;
    while ((pos % FRAME) != target && n < 200) begin step(); n++; end
    chk("run_to_reached", 32'(pos % FRAME), 32'(target));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; habilitar = 1'b0; cargar = 1'b0; codigo_BCD = '0;
    pos = 0; m_shadow = 0; m_pending = 0; m_pend = 0; m_err = 0; m_fin = 0; m_en = 0;
    run(2);
    chk("rst_anodo", 32'(anodo_n), 32'hF);
    chk("rst_digito", 32'(digito), 32'h0);

    // Basic scan of 1234.
    rst_n = 1'b1; habilitar = 1'b1;
    pulse_load(16'h1234);
    run_to(FRAME - 1);
    step();
    chk("first_frame_digit0", 32'(digito), 32'h4);
    chk("first_frame_anodo", 32'(anodo_n), 32'hE);
    run(2 * FRAME);

    // Tear-free update requested while digit 1 is shown.
    run_to(RD + 1);
    pulse_load(16'h5678);
    run_to(2 * RD);
    chk("tearfree_d2", 32'(digito), 32'h2);
    run_to(FRAME - 1);
    step();
    chk("new_frame_d0", 32'(digito), 32'h8);
    run(FRAME);

    // Load coinciding with the frame boundary.
    run_to(FRAME - 1);
    pulse_load(16'h9999);
    chk("sim_load_digit", 32'(digito), 32'h9);
    run(3);
    pulse_load(16'h0001);
    run(2);
    pulse_load(16'h0002);
    run_to(FRAME - 1);
    step();
    chk("latest_wins", 32'(digito), 32'h2);

    // Pause mid-frame at idx 2, prescaler 1.
    run_to(2 * RD + 1);
    habilitar = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("paused_blank", 32'(anodo_n), 32'hF);
    end
    habilitar = 1'b1;
    run(3);
    step();
    chk("resume_idx", 32'(contador_actualizar), 32'h3);

    // Reset while a load is pending.
    pulse_load(16'h4321);
    rst_n = 1'b0;
    step();
    chk("rst_mid_idx", 32'(contador_actualizar), 32'h0);
    chk("rst_mid_anodo", 32'(anodo_n), 32'hF);
    rst_n = 1'b1;
    run(2 * FRAME);

    // Invalid BCD sets a sticky flag.
    pulse_load(16'h00A5);
    run(FRAME + 3);
    chk("err_sticky", 32'(error_bcd), 32'h1);

    // Small value (leading zeros when blanking is enabled).
    rst_n = 1'b0; step(); rst_n = 1'b1;
    pulse_load(16'h0042);
    run(3 * FRAME);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      habilitar = ($urandom_range(0, 9) != 0);
      cargar    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0)
        codigo_BCD = 16'($urandom);
      else
        for (int k = 0; k < N; k++) codigo_BCD[4*k +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) codigo_BCD[15:8] = 8'h00;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
